// File: rtl/ccff_pkg.sv
// Shared types and width helpers for the configuration-chain loader.
package ccff_pkg;

  // Sequencer states; the encoding is also exported on the debug port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    MARK   = 3'd2,
    LOAD   = 3'd3,
    FINISH = 3'd4
  } ccff_state_t;

  // Width of the shift counter: must reach CHAIN_LEN + PROBE_SLACK.
  function automatic int bit_cnt_w(input int chain_len, input int slack);
    return $clog2(chain_len + slack + 1);
  endfunction

  // Width of the per-word bit index: must hold the value WORD_W.
  function automatic int word_idx_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

  // Number of bitstream words needed to fill the chain (ceiling division).
  function automatic int words_per_chain(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_serializer.sv
// WORD_W -> 1 MSB-first shift register feeding the chain.
// It is "empty" once the last bit of the current word is being presented,
// so a new word can be taken in that same cycle and streaming has no bubble.
// bit_out/fire describe the bit that must appear on ccff_head next cycle.
module ccff_serializer
  import ccff_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int IDX_W  = word_idx_w(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              more,
  input  logic [WORD_W-1:0] data,
  input  logic              valid,
  input  logic [IDX_W-1:0]  keep,
  output logic              ready,
  output logic              take,
  output logic              bit_out,
  output logic              fire
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [WORD_W-1:0] sreg;
  logic [IDX_W-1:0]  cnt;

  assign ready   = more && (cnt == '0);
  assign take    = ready && valid;
  assign fire    = take || (cnt != '0);
  assign bit_out = take ? data[WORD_W-1] : sreg[WORD_W-1];

  // Load a new word (its MSB leaves immediately) or advance the pending bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (take) begin
      sreg <= data << 1;
      cnt  <= keep - IDX_ONE;
    end else if (cnt != '0) begin
      sreg <= sreg << 1;
      cnt  <= cnt - IDX_ONE;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: optional chain-length probe, then a load of
// exactly CHAIN_LEN bits streamed MSB-first onto ccff_head.
//
// Stream handshake: a word transfers on every rising prog_clk edge where
// cfg_valid && cfg_ready; cfg_ready never depends on cfg_valid, and the
// loader never consumes a word outside the LOAD state.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN   = 64,
  parameter int WORD_W      = 8,
  parameter int PROBE_SLACK = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              probe_en,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output ccff_state_t       dbg_state
);

  localparam int CNT_W     = bit_cnt_w(CHAIN_LEN, PROBE_SLACK);
  localparam int IDX_W     = word_idx_w(WORD_W);
  localparam int NWORDS    = words_per_chain(CHAIN_LEN, WORD_W);
  localparam int WCNT_W    = $clog2(NWORDS + 1);
  localparam int LAST_KEEP = CHAIN_LEN - (NWORDS - 1) * WORD_W;

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_CHAIN  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(CHAIN_LEN + PROBE_SLACK);
  localparam logic [IDX_W-1:0]  KEEP_FULL  = IDX_W'(WORD_W);
  localparam logic [IDX_W-1:0]  KEEP_LAST  = IDX_W'(LAST_KEEP);
  localparam logic [WCNT_W-1:0] WORDS_ALL  = WCNT_W'(NWORDS);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);

  ccff_state_t       state;
  logic [CNT_W-1:0]  n;
  logic [WCNT_W-1:0] words_left;
  logic              reflush;

  logic              ser_more;
  logic [IDX_W-1:0]  ser_keep;
  logic              ser_ready;
  logic              ser_take;
  logic              ser_bit;
  logic              ser_fire;

  assign ser_more  = (state == LOAD) && (words_left != '0);
  assign ser_keep  = (words_left == WCNT_ONE) ? KEEP_LAST : KEEP_FULL;
  assign cfg_ready = ser_ready;
  assign dbg_state = state;

  ccff_serializer #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_ser (
    .clk     (prog_clk),
    .rst     (pReset),
    .more    (ser_more),
    .data    (cfg_data),
    .valid   (cfg_valid),
    .keep    (ser_keep),
    .ready   (ser_ready),
    .take    (ser_take),
    .bit_out (ser_bit),
    .fire    (ser_fire)
  );

  // Sequencer: every chain-facing output is a flop set one cycle ahead.
  // In FLUSH, n counts the zero shift being presented (1..CHAIN_LEN); in
  // MARK, n counts shifts already completed since the marker went in.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state         <= IDLE;
      n             <= '0;
      words_left    <= '0;
      reflush       <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ccff_shift_en <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            error   <= 1'b0;
            reflush <= 1'b0;
            if (probe_en) begin
              state         <= FLUSH;
              n             <= CNT_ONE;
              ccff_head     <= 1'b0;
              ccff_shift_en <= 1'b1;
            end else begin
              state      <= LOAD;
              words_left <= WORDS_ALL;
            end
          end
        end
        FLUSH: begin
          ccff_head     <= 1'b0;
          ccff_shift_en <= 1'b1;
          if (n == CNT_CHAIN) begin
            if (reflush) begin
              state         <= LOAD;
              words_left    <= WORDS_ALL;
              ccff_shift_en <= 1'b0;
            end else begin
              state     <= MARK;
              n         <= '0;
              ccff_head <= 1'b1;
            end
          end else begin
            n <= n + CNT_ONE;
          end
        end
        MARK: begin
          ccff_head <= 1'b0;
          if (ccff_tail && (n == CNT_CHAIN)) begin
            // Chain length proven; flush once more to wipe the marker.
            state         <= FLUSH;
            reflush       <= 1'b1;
            n             <= CNT_ONE;
            ccff_shift_en <= 1'b1;
          end else if (ccff_tail || (n == CNT_LIMIT)) begin
            state         <= IDLE;
            error         <= 1'b1;
            busy          <= 1'b0;
            ccff_shift_en <= 1'b0;
          end else begin
            n             <= n + CNT_ONE;
            ccff_shift_en <= 1'b1;
          end
        end
        LOAD: begin
          ccff_shift_en <= ser_fire;
          if (ser_fire) begin
            ccff_head <= ser_bit;
          end
          if (ser_take) begin
            words_left <= words_left - WCNT_ONE;
          end
          if ((words_left == '0) && !ser_fire) begin
            state         <= FINISH;
            done          <= 1'b1;
            ccff_shift_en <= 1'b0;
          end
        end
        FINISH: begin
          state         <= IDLE;
          busy          <= 1'b0;
          ccff_shift_en <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          ccff_shift_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 64/8 instance (plain, backpressure, probe,
// reset) with a behavioural chain, and a 20/8 instance for partial words.
// The model is the expected serial bit stream on ccff_head, built from words
// and probe rules; a compare process checks every shift against it.
`timescale 1ns/1ps
module tb_ccff_chain_loader;
  import ccff_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: CHAIN_LEN=64 ----------------
  logic         a_start = 1'b0, a_probe = 1'b0, a_valid, a_ready;
  logic [W-1:0] a_data;
  logic         a_head, a_en, a_tail, a_busy, a_done, a_error;
  ccff_state_t  a_state;

  ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(W), .PROBE_SLACK(8)) u_a (
    .prog_clk(clk), .pReset(rst), .start(a_start), .probe_en(a_probe),
    .cfg_data(a_data), .cfg_valid(a_valid), .cfg_ready(a_ready),
    .ccff_head(a_head), .ccff_shift_en(a_en), .ccff_tail(a_tail),
    .busy(a_busy), .done(a_done), .error(a_error), .dbg_state(a_state)
  );

  // ---------------- DUT B: CHAIN_LEN=20 ----------------
  logic         b_start = 1'b0, b_valid, b_ready;
  logic [W-1:0] b_data;
  logic         b_head, b_en, b_busy, b_done, b_error;
  ccff_state_t  b_state;

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(W), .PROBE_SLACK(8)) u_b (
    .prog_clk(clk), .pReset(rst), .start(b_start), .probe_en(1'b0),
    .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .ccff_head(b_head), .ccff_shift_en(b_en), .ccff_tail(1'b0),
    .busy(b_busy), .done(b_done), .error(b_error), .dbg_state(b_state)
  );

  // ---------------- behavioural chain for A ----------------
  logic a_chain [0:127];
  int   a_chain_len = 64;
  bit   a_stuck = 1'b0;

  // Chain flops: shift toward the tail whenever the loader enables a shift.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) a_chain[i] <= 1'b0;
    end else if (a_en) begin
      for (int i = 127; i > 0; i--) a_chain[i] <= a_chain[i-1];
      a_chain[0] <= a_head;
    end
  end
  assign a_tail = a_stuck ? 1'b0 : a_chain[a_chain_len-1];

  // ---------------- scoreboard ----------------
  logic [0:0]   a_exp_q[$];
  logic [0:0]   b_exp_q[$];
  logic [W-1:0] a_src_q[$];
  logic [W-1:0] b_src_q[$];
  int checks = 0, failures = 0;
  int a_shifts = 0, a_acc = 0, a_dones = 0;
  int b_shifts = 0, b_acc = 0, b_dones = 0;
  bit a_toggle = 1'b0;
  logic [0:0] a_e, b_e;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void a_push_bits(input logic [W-1:0] w, input int keep);
    for (int j = 0; j < keep; j++) a_exp_q.push_back(w[W-1-j]);
  endfunction

  function automatic void a_push_zeros(input int cnt);
    for (int j = 0; j < cnt; j++) a_exp_q.push_back(1'b0);
  endfunction

  function automatic void b_push_bits(input logic [W-1:0] w, input int keep);
    for (int j = 0; j < keep; j++) b_exp_q.push_back(w[W-1-j]);
  endfunction

  // Word k of the chain image: the first streamed bit sits deepest (index 63).
  function automatic logic [W-1:0] a_image_word(input int k);
    logic [W-1:0] r;
    for (int j = 0; j < W; j++) r[W-1-j] = a_chain[63 - W*k - j];
    return r;
  endfunction

  function automatic logic [W-1:0] a_exp_byte(input int base);
    logic [W-1:0] r;
    for (int j = 0; j < W; j++) r[W-1-j] = a_exp_q[base+j];
    return r;
  endfunction

  // Compare process: every shift must carry the next expected bit.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (a_en) begin
          if (a_exp_q.size() == 0) chk("a_extra_shift", 1, 0);
          else begin
            a_e = a_exp_q.pop_front();
            chk("a_head", int'(a_head), int'(a_e));
          end
          a_shifts++;
        end
        if (a_valid && a_ready) a_acc++;
        if (a_done) a_dones++;
        if (a_ready) chk("a_ready_only_when_busy", int'(a_busy), 1);
        if (b_en) begin
          if (b_exp_q.size() == 0) chk("b_extra_shift", 1, 0);
          else begin
            b_e = b_exp_q.pop_front();
            chk("b_head", int'(b_head), int'(b_e));
          end
          b_shifts++;
        end
        if (b_valid && b_ready) b_acc++;
        if (b_done) b_dones++;
        if (b_ready) chk("b_ready_only_when_busy", int'(b_busy), 1);
      end
    end
  end

  // ---------------- stream drivers ----------------
  bit a_fire, a_phase = 1'b0, b_fire;

  // Source A: presents the queue head; optionally toggles valid every cycle.
  initial begin
    a_valid = 1'b0;
    a_data  = '0;
    forever begin
      @(negedge clk);
      a_fire = a_valid && a_ready && !rst;
      @(posedge clk);
      #1;
      if (a_fire && a_src_q.size() > 0) void'(a_src_q.pop_front());
      a_phase = ~a_phase;
      a_valid = (a_src_q.size() > 0) && (!a_toggle || a_phase);
      a_data  = (a_src_q.size() > 0) ? a_src_q[0] : '0;
    end
  end

  // Source B: valid held high whenever words are queued.
  initial begin
    b_valid = 1'b0;
    b_data  = '0;
    forever begin
      @(negedge clk);
      b_fire = b_valid && b_ready && !rst;
      @(posedge clk);
      #1;
      if (b_fire && b_src_q.size() > 0) void'(b_src_q.pop_front());
      b_valid = (b_src_q.size() > 0);
      b_data  = (b_src_q.size() > 0) ? b_src_q[0] : '0;
    end
  end

  task automatic a_pulse_start(input bit probe);
    @(posedge clk); #1;
    a_probe = probe;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_probe = 1'b0;
  endtask

  task automatic wait_idle(input bit use_b, input int budget, input string nm);
    int c = 0;
    while ((use_b ? b_busy : a_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, int'(use_b ? b_busy : a_busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic a_new_run();
    a_exp_q.delete();
    a_src_q.delete();
    a_shifts = 0;
    a_acc    = 0;
    a_dones  = 0;
  endtask

  task automatic a_queue_words(input bit extra);
    for (int k = 0; k < 8; k++) begin
      a_src_q.push_back(W'(8'hA5 + k));
      a_push_bits(W'(8'hA5 + k), W);
    end
    if (extra) a_src_q.push_back(8'hAD);
  endtask

  task automatic a_check_image(input string nm);
    for (int k = 0; k < 8; k++) chk(nm, int'(a_image_word(k)), 8'hA5 + k);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    chk("reset_a_outputs", int'({a_ready, a_head, a_en, a_busy, a_done, a_error}), 0);
    chk("reset_b_outputs", int'({b_ready, b_head, b_en, b_busy, b_done, b_error}), 0);
    chk("reset_a_state", int'(a_state), int'(IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Plain load, valid always high, one spare word that must stay queued.
    a_new_run();
    a_queue_words(1'b1);
    chk("model_len_64", a_exp_q.size(), 64);
    chk("model_first_byte", int'(a_exp_byte(0)), 8'hA5);
    chk("model_last_byte", int'(a_exp_byte(56)), 8'hAC);
    a_pulse_start(1'b0);
    wait_idle(1'b0, 300, "plain_timeout");
    chk("plain_shifts", a_shifts, 64);
    chk("plain_exp_left", a_exp_q.size(), 0);
    chk("plain_done_count", a_dones, 1);
    chk("plain_words", a_acc, 8);
    chk("plain_spare_kept", a_src_q.size(), 1);
    chk("plain_error", int'(a_error), 0);
    chk("plain_deepest_bit", int'(a_chain[63]), 1);
    a_check_image("plain_image");

    // Backpressure: valid toggles every cycle.
    a_new_run();
    a_toggle = 1'b1;
    a_queue_words(1'b0);
    a_pulse_start(1'b0);
    wait_idle(1'b0, 400, "bp_timeout");
    chk("bp_shifts", a_shifts, 64);
    chk("bp_exp_left", a_exp_q.size(), 0);
    chk("bp_done_count", a_dones, 1);
    a_check_image("bp_image");
    a_toggle = 1'b0;

    // Probe pass: 64 flush, marker + 64, 64 re-flush, then 64 data bits.
    a_new_run();
    a_chain_len = 64;
    a_push_zeros(64);
    a_exp_q.push_back(1'b1);
    a_push_zeros(64 + 64);
    a_queue_words(1'b0);
    a_pulse_start(1'b1);
    wait_idle(1'b0, 800, "pass_timeout");
    chk("pass_shifts", a_shifts, 257);
    chk("pass_exp_left", a_exp_q.size(), 0);
    chk("pass_done_count", a_dones, 1);
    chk("pass_error", int'(a_error), 0);
    a_check_image("pass_image");

    // Probe fail on a 60-flop chain; words wait on the stream unconsumed.
    a_new_run();
    a_chain_len = 60;
    a_push_zeros(64);
    a_exp_q.push_back(1'b1);
    a_push_zeros(60);
    for (int k = 0; k < 8; k++) a_src_q.push_back(W'(8'h11 * k));
    a_pulse_start(1'b1);
    wait_idle(1'b0, 400, "short_timeout");
    chk("short_shifts", a_shifts, 125);
    chk("short_exp_left", a_exp_q.size(), 0);
    chk("short_error", int'(a_error), 1);
    chk("short_done_count", a_dones, 0);
    chk("short_words", a_acc, 0);

    // Broken chain (tail stuck 0): give up after 72 post-marker shifts.
    a_new_run();
    a_chain_len = 64;
    a_stuck = 1'b1;
    a_push_zeros(64);
    a_exp_q.push_back(1'b1);
    a_push_zeros(72);
    a_pulse_start(1'b1);
    wait_idle(1'b0, 400, "stuck_timeout");
    chk("stuck_shifts", a_shifts, 137);
    chk("stuck_error", int'(a_error), 1);
    chk("stuck_done_count", a_dones, 0);
    a_stuck = 1'b0;

    // New start clears the sticky error; reset lands after 30 shifts.
    a_new_run();
    a_queue_words(1'b0);
    a_pulse_start(1'b0);
    @(negedge clk);
    chk("restart_error_cleared", int'(a_error), 0);
    chk("restart_busy", int'(a_busy), 1);
    for (int c = 0; c < 200 && a_shifts < 30; c++) @(negedge clk);
    chk("midload_reached_30", a_shifts, 30);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({a_ready, a_head, a_en, a_busy, a_done, a_error}), 0);
    chk("async_reset_state", int'(a_state), int'(IDLE));
    a_new_run();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    a_queue_words(1'b0);
    a_pulse_start(1'b0);
    wait_idle(1'b0, 300, "reload_timeout");
    chk("reload_shifts", a_shifts, 64);
    chk("reload_done_count", a_dones, 1);
    a_check_image("reload_image");

    // Partial final word on the 20-flop instance; 4th word must stay queued.
    b_src_q.push_back(8'h3C);
    b_src_q.push_back(8'h96);
    b_src_q.push_back(8'hE7);
    b_src_q.push_back(8'h5A);
    b_push_bits(8'h3C, 8);
    b_push_bits(8'h96, 8);
    b_push_bits(8'hE7, 4);
    chk("model_b_len", b_exp_q.size(), 20);
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    wait_idle(1'b1, 200, "partial_timeout");
    chk("partial_shifts", b_shifts, 20);
    chk("partial_words", b_acc, 3);
    chk("partial_exp_left", b_exp_q.size(), 0);
    chk("partial_done_count", b_dones, 1);
    chk("partial_spare_kept", b_src_q.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequences the configuration-chain (ccff) load of a string of IO/logic tiles whose ccff_head→ccff_tail flops are clocked by prog_clk and cleared by pReset.
- Accepts bitstream words over a valid/ready stream and serialises them MSB-first onto ccff_head, driving a shift enable that the tile column uses to gate its prog_clk.
- Optionally runs a chain-integrity probe before the load, to prove that the chain length equals CHAIN_LEN.
- Sits between the bitstream DMA/SPI front end and the first tile's ccff_head.

Parameters:
- CHAIN_LEN, 64: number of config flops between ccff_head and ccff_tail, ≥2.
- WORD_W, 8: bitstream word width, ≥1.
- PROBE_SLACK, 8: extra shifts allowed past CHAIN_LEN before the probe declares failure.

Ports:
- prog_clk  in  1  configuration clock; all state on rising edge.
- pReset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sequence when idle, ignored otherwise.
- probe_en  in  1  sampled with start; 1 = run the probe before the load.
- cfg_data  in  WORD_W  bitstream word, MSB shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted when cfg_valid & cfg_ready.
- ccff_head  out  1  serial bit into the chain (registered).
- ccff_shift_en  out  1  chain advances one bit on every prog_clk edge where this is 1 (registered, aligned with ccff_head).
- ccff_tail  in  1  serial bit out of the chain.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky probe failure; cleared by the next accepted start or by pReset.

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters 0; shift register empty.
- States: IDLE, FLUSH, MARK, LOAD, FINISH.
- IDLE:
  - start=1 → busy=1 and error cleared.
  - Next state is FLUSH if probe_en=1, otherwise LOAD.
- FLUSH:
  - Drives ccff_head=0 with ccff_shift_en=1 for exactly CHAIN_LEN cycles, then enters MARK.
- MARK:
  - First cycle: ccff_head=1 (marker); afterwards ccff_head=0; ccff_shift_en=1 throughout.
  - The shift counter n counts shifts, starting with the marker shift as n=1.
  - ccff_tail is sampled every cycle of MARK.
  - ccff_tail=1 observed with n==CHAIN_LEN → pass; the next state is FLUSH-then-LOAD (a second flush re-clears the marker). A single re-flush is acceptable, implemented as a flag.
  - ccff_tail=1 observed with n≠CHAIN_LEN, or n reaches CHAIN_LEN+PROBE_SLACK without a marker → error=1 and state goes to IDLE (busy=0, no done).
- LOAD:
  - cfg_ready=1 only when the shift register is empty and bits remaining >0.
  - An accepted word loads the shift register.
  - Each following cycle shifts one bit: ccff_head=bit, ccff_shift_en=1.
  - No bubble is allowed when cfg_valid is already high. cfg_ready is asserted in the same cycle the last bit of the previous word is shifted.
  - Total shifts = CHAIN_LEN exactly. The number of words is ceil(CHAIN_LEN/WORD_W).
  - Low-order surplus bits of the final word are discarded and never shifted.
  - If cfg_valid is low, ccff_shift_en=0 and ccff_head holds its value; the chain does not advance.
- FINISH:
  - One cycle with ccff_shift_en=0 and done=1, then IDLE with busy=0.
- Width rules:
  - Bit counter is $clog2(CHAIN_LEN+PROBE_SLACK+1) bits.
  - Word bit index is $clog2(WORD_W+1) bits.
- Boundary conditions:
  - start while busy: ignored.
  - pReset mid-sequence: immediate return to reset values. The chain is also cleared by pReset, so a restart is always clean.
  - cfg_valid held high in IDLE/FLUSH/MARK: cfg_ready=0 and no word is consumed.
  - CHAIN_LEN a multiple of WORD_W: no bits are discarded.
  - WORD_W=1: one word per shift, continuous streaming at full rate.

Decomposition:
- Shared package ccff_pkg holds:
  - the state enum (IDLE, FLUSH, MARK, LOAD, FINISH);
  - the localparam width helpers (counter widths, words-per-chain).
- One natural sub-module: ccff_serializer, the WORD_W→1 MSB-first shift register with empty/ready logic and a "bits to keep" input for the final word.
- The FSM and counters live in the top module.

Test Plan:
- Plain load, CHAIN_LEN=64, WORD_W=8, probe_en=0:
  - Stimulus: 8 words 0xA5..0xAC with valid always high.
  - Response: exactly 64 cycles of ccff_shift_en, head sequence equals the words MSB-first, done pulses once, cfg_ready deasserts after word 8.
- Backpressure:
  - Stimulus: same load with cfg_valid toggling 1/0 each cycle.
  - Response: the shift_en gaps match the valid gaps, still 64 shifts in total, bitstream unchanged.
- Probe pass:
  - Stimulus: behavioural 64-flop chain model, probe_en=1.
  - Response: marker seen at n=64, error=0, load proceeds, chain model content equals the loaded bitstream at done.
- Probe fail:
  - Stimulus: chain model of 60 flops.
  - Response: marker seen at n=60, error=1, busy drops, no done, no cfg_ready ever.
  - Repeat with a broken chain (tail stuck 0): error asserted after n=72.
- Partial word, CHAIN_LEN=20, WORD_W=8:
  - Response: 3 words accepted, exactly 20 shifts, the low 4 bits of word 3 are never driven.
- Reset mid-load:
  - Stimulus: assert pReset after 30 shifts, then restart.
  - Response: all outputs are 0 asynchronously, and the restarted load completes with done and a correct chain image.
